cordic_exp: RTL

- Iterative hyperbolic-rotation CORDIC that computes o_exp = e^x for a signed Q4.8 input; the exponential counterpart of the calculator's CORDIC natural-log unit.
- Sits on the calculator datapath between the operand register and the result mux.
- Uses a start/busy/done handshake.
- Range reduction by ln2 steps, then a rotation loop, then a 2^q scale. One multi-cycle FSM, no pipeline.

---
 rtl/cordic_exp_if.sv | 23 ++
 rtl/cordic_exp.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cordic_exp_if.sv
// Handshake bundle for cordic_exp: clock enable, start/operand in,
// busy/result/done out.
interface cordic_exp_if #(
   parameter int N = 12,
   parameter int M = 24
) ();
   logic         i_ce;
   logic         i_start;
   logic [N-1:0] i_val;
   logic         o_busy;
   logic [M-1:0] o_exp;
   logic         o_done;

   modport master (
      output i_ce, i_start, i_val,
      input  o_busy, o_exp, o_done
   );

   modport slave (
      input  i_ce, i_start, i_val,
      output o_busy, o_exp, o_done
   );
endinterface

// File: rtl/cordic_exp.sv
// cordic_exp: iterative hyperbolic CORDIC computing e^x.
// Input signed Q4.8, output unsigned Q16.8, working format signed Q16.16.
// Flow: ln2 range reduction -> 18 rotation steps -> 2^q scale -> convert.
// Optional macro CORDIC_EXP_ROUND_EN: round-half-up on the Q16.8
// conversion instead of truncation (same latency).
module cordic_exp #(
   parameter int N          = 12,
   parameter int M          = 24,
   parameter int W          = 32,
   parameter int ITERATIONS = 18
) (
   input  logic         CLK,
   input  logic         RST,
   cordic_exp_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REDUCE,
      S_ROTATE,
      S_SCALE,
      S_FINISH
   } state_t;

   localparam logic signed [W-1:0] LN2      = W'(45426);
   localparam logic signed [W-1:0] INV_GAIN = W'(79134);
   localparam logic signed [W-1:0] ONE      = W'(65536);
   localparam logic [4:0]          LAST_IT  = 5'(ITERATIONS - 1);

   state_t                state_q, state_d;
   logic signed [W-1:0]   x_q, x_d;
   logic signed [W-1:0]   y_q, y_d;
   logic signed [W-1:0]   z_q, z_d;
   logic signed [W-1:0]   s_q, s_d;
   logic signed [4:0]     q_q, q_d;
   logic [4:0]            it_q, it_d;
   logic [M-1:0]          exp_q, exp_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic [4:0]            k;
   logic signed [W-1:0]   xs, ys, ang;
   logic signed [W-1:0]   sum;
   logic [4:0]            shamt;
   logic signed [W-1:0]   rnd;
   logic [W+M:0]          wide;

   // Shift index for iteration i: 1..4, 4, 5..13, 13, 14..16
   function automatic logic [4:0] shift_idx(input logic [4:0] i);
      if (i <= 5'd3)       return i + 5'd1;
      else if (i <= 5'd13) return (i == 5'd4) ? 5'd4 : i;
      else                 return i - 5'd1;
   endfunction

   // atanh(2^-k) in Q16.16
   function automatic logic signed [W-1:0] atanh_lut(input logic [4:0] kk);
      case (kk)
         5'd1:    return W'(35999);
         5'd2:    return W'(16739);
         5'd3:    return W'(8235);
         5'd4:    return W'(4101);
         5'd5:    return W'(2049);
         5'd6:    return W'(1024);
         5'd7:    return W'(512);
         5'd8:    return W'(256);
         5'd9:    return W'(128);
         5'd10:   return W'(64);
         5'd11:   return W'(32);
         5'd12:   return W'(16);
         5'd13:   return W'(8);
         5'd14:   return W'(4);
         5'd15:   return W'(2);
         5'd16:   return W'(1);
         default: return '0;
      endcase
   endfunction

   // Next-state and datapath for every FSM state
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      s_d     = s_q;
      q_d     = q_q;
      it_d    = it_q;
      exp_d   = exp_q;
      done_d  = 1'b0;

      k     = shift_idx(it_q);
      xs    = x_q >>> k;
      ys    = y_q >>> k;
      ang   = atanh_lut(k);
      sum   = x_q + y_q;
      shamt = q_q[4] ? 5'(-q_q) : 5'(q_q);
`ifdef CORDIC_EXP_ROUND_EN
      rnd   = s_q + W'(128);
`else
      rnd   = s_q;
`endif
      wide  = {{(M+1){1'b0}}, rnd};

      case (state_q)
         S_IDLE: begin
            if (bus.i_start) begin
               z_d = {{(W-N-8){bus.i_val[N-1]}}, bus.i_val, 8'b0};
               q_d = '0;
               if (bus.i_val == '0) begin
                  // Zero operand bypasses reduction/rotation: SCALE with
                  // x=1.0, y=0, q=0 yields exactly 1.0 one cycle later.
                  x_d     = ONE;
                  y_d     = '0;
                  state_d = S_SCALE;
               end else begin
                  state_d = S_REDUCE;
               end
            end
         end
         S_REDUCE: begin
            if (z_q >= LN2) begin
               z_d = z_q - LN2;
               q_d = q_q + 5'sd1;
            end else if (z_q[W-1]) begin
               z_d = z_q + LN2;
               q_d = q_q - 5'sd1;
            end else begin
               x_d     = INV_GAIN;
               y_d     = '0;
               it_d    = '0;
               state_d = S_ROTATE;
            end
         end
         S_ROTATE: begin
            if (z_q[W-1]) begin
               x_d = x_q - ys;
               y_d = y_q - xs;
               z_d = z_q + ang;
            end else begin
               x_d = x_q + ys;
               y_d = y_q + xs;
               z_d = z_q - ang;
            end
            it_d = it_q + 5'd1;
            if (it_q == LAST_IT) state_d = S_SCALE;
         end
         S_SCALE: begin
            s_d     = q_q[4] ? (sum >>> shamt) : (sum <<< shamt);
            state_d = S_FINISH;
         end
         S_FINISH: begin
            if (rnd[W-1])             exp_d = '0;
            else if (|wide[W+M:M+8])  exp_d = '1;
            else                      exp_d = wide[M+7:8];
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs; clock enable freezes everything
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         s_q     <= '0;
         q_q     <= '0;
         it_q    <= '0;
         exp_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (bus.i_ce) begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         s_q     <= s_d;
         q_q     <= q_d;
         it_q    <= it_d;
         exp_q   <= exp_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.o_busy = busy_q;
   assign bus.o_exp  = exp_q;
   assign bus.o_done = done_q;

endmodule
